// File: rtl/minigame_round_if.sv
// Purpose : bundles the game-facing signals of the button-match round sequencer.
// Signals : start, button[3:0]          -> into the sequencer
//           target, round_active, correct_p, wrong_p, timeout_p,
//           score[SCORE_W-1:0], lives[3:0], game_over, time_left[31:0] <- from the sequencer
// Modports: master = stimulus/display side, slave = sequencer side.
interface minigame_round_if #(
    parameter int unsigned SCORE_W = 8
);
    logic               start;
    logic [3:0]         button;
    logic [1:0]         target;
    logic               round_active;
    logic               correct_p;
    logic               wrong_p;
    logic               timeout_p;
    logic [SCORE_W-1:0] score;
    logic [3:0]         lives;
    logic               game_over;
    logic [31:0]        time_left;

    modport master (
        output start, button,
        input  target, round_active, correct_p, wrong_p, timeout_p,
        input  score, lives, game_over, time_left
    );

    modport slave (
        input  start, button,
        output target, round_active, correct_p, wrong_p, timeout_p,
        output score, lives, game_over, time_left
    );
endinterface

// File: rtl/minigame_round_ctrl.sv
// Purpose : round sequencer for the button-match minigame. Draws a 2-bit target from a
//           free-running LFSR, arms a response window, judges the first press
//           (correct / wrong / timeout), keeps score and lives, ends the game at 0 lives.
// Ports   : clock  - system clock
//           reset  - synchronous, active-high reset
//           bus    - minigame_round_if.slave (start/button in; target, round_active,
//                    correct_p/wrong_p/timeout_p pulses, score, lives, game_over,
//                    time_left out). All outputs are registered.
// Config  : define ROUND_SPEEDUP_EN to shrink the window by window>>3 after every
//           correct round, floored at TIMEOUT_CYCLES/4 (restored on start and reset).
module minigame_round_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter int unsigned LIVES          = 3,
    parameter logic [15:0] SEED           = 16'h1C7F,
    parameter int unsigned SCORE_W        = 8
) (
    input  logic             clock,
    input  logic             reset,
    minigame_round_if.slave  bus
);

    localparam logic [15:0]        LFSR_MASK  = 16'hB400;
    localparam logic [15:0]        LFSR_INIT  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [31:0]        WINDOW_MAX = 32'(TIMEOUT_CYCLES);
    localparam logic [3:0]         LIVES_INIT = 4'(LIVES);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEW_ROUND,
        ST_WAIT_RELEASE,
        ST_WAIT_PRESS,
        ST_RESULT,
        ST_GAME_OVER
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [1:0]         target_q, target_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [3:0]         lives_q, lives_d;
    logic [31:0]        time_left_q, time_left_d;
    logic               round_active_q, round_active_d;
    logic               game_over_q, game_over_d;
    logic               correct_q, correct_d;
    logic               wrong_q, wrong_d;
    logic               timeout_q, timeout_d;
    logic [31:0]        window_load;

    logic pressed;
    logic press_ok;

    assign pressed  = (bus.button != 4'b0000);
    assign press_ok = (bus.button == (4'b0001 << target_q));

`ifdef ROUND_SPEEDUP_EN
    localparam logic [31:0] WINDOW_FLOOR = 32'(TIMEOUT_CYCLES / 4);
    logic [31:0] window_q, window_d;
    logic [31:0] window_shrunk;

    assign window_load   = window_q;
    assign window_shrunk = window_q - (window_q >> 3);
`else
    assign window_load = WINDOW_MAX;
`endif

    // Galois LFSR, advanced every cycle regardless of state
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lfsr_q         <= LFSR_INIT;
            target_q       <= 2'd0;
            score_q        <= '0;
            lives_q        <= LIVES_INIT;
            time_left_q    <= 32'd0;
            round_active_q <= 1'b0;
            game_over_q    <= 1'b0;
            correct_q      <= 1'b0;
            wrong_q        <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef ROUND_SPEEDUP_EN
            window_q       <= WINDOW_MAX;
`endif
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            target_q       <= target_d;
            score_q        <= score_d;
            lives_q        <= lives_d;
            time_left_q    <= time_left_d;
            round_active_q <= round_active_d;
            game_over_q    <= game_over_d;
            correct_q      <= correct_d;
            wrong_q        <= wrong_d;
            timeout_q      <= timeout_d;
`ifdef ROUND_SPEEDUP_EN
            window_q       <= window_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:         if (bus.start) state_d = ST_NEW_ROUND;
            ST_NEW_ROUND:    state_d = ST_WAIT_RELEASE;
            ST_WAIT_RELEASE: if (!pressed) state_d = ST_WAIT_PRESS;
            ST_WAIT_PRESS:   if (pressed || (time_left_q == 32'd1)) state_d = ST_RESULT;
            ST_RESULT:       state_d = (lives_q == 4'd0) ? ST_GAME_OVER : ST_NEW_ROUND;
            ST_GAME_OVER:    if (bus.start) state_d = ST_NEW_ROUND;
            default:         state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        target_d       = target_q;
        score_d        = score_q;
        lives_d        = lives_q;
        time_left_d    = time_left_q;
        correct_d      = 1'b0;
        wrong_d        = 1'b0;
        timeout_d      = 1'b0;
        round_active_d = (state_d == ST_WAIT_PRESS);
        game_over_d    = (state_d == ST_GAME_OVER);
`ifdef ROUND_SPEEDUP_EN
        window_d       = window_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (bus.start) begin
                    score_d  = '0;
                    lives_d  = LIVES_INIT;
`ifdef ROUND_SPEEDUP_EN
                    window_d = WINDOW_MAX;
`endif
                end
            end
            ST_NEW_ROUND: target_d = lfsr_q[1:0];
            ST_WAIT_RELEASE: begin
                if (!pressed) time_left_d = window_load;
            end
            ST_WAIT_PRESS: begin
                time_left_d = time_left_q - 32'd1;
                // A press wins over an expiring window on the same cycle
                if (pressed) begin
                    time_left_d = 32'd0;
                    if (press_ok) begin
                        correct_d = 1'b1;
                        if (score_q != SCORE_MAX) score_d = score_q + SCORE_W'(1);
`ifdef ROUND_SPEEDUP_EN
                        window_d = (window_shrunk < WINDOW_FLOOR) ? WINDOW_FLOOR : window_shrunk;
`endif
                    end else begin
                        wrong_d = 1'b1;
                        if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                    end
                end else if (time_left_q == 32'd1) begin
                    time_left_d = 32'd0;
                    timeout_d   = 1'b1;
                    if (lives_q != 4'd0) lives_d = lives_q - 4'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.target       = target_q;
    assign bus.round_active = round_active_q;
    assign bus.correct_p    = correct_q;
    assign bus.wrong_p      = wrong_q;
    assign bus.timeout_p    = timeout_q;
    assign bus.score        = score_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = game_over_q;
    assign bus.time_left    = time_left_q;

endmodule

// File: tb/tb_minigame_round_ctrl.sv
// Purpose : self-checking bench for minigame_round_ctrl (TIMEOUT_CYCLES=20, LIVES=2,
//           SEED=16'h1C7F, SCORE_W=3 so saturation is reachable). Directed steps followed
//           by randomized rounds, all judged by a round-level game model.
`timescale 1ns/1ps
module tb_minigame_round_ctrl;

    localparam int unsigned T    = 20;
    localparam int unsigned L    = 2;
    localparam int unsigned SW   = 3;
    localparam logic [15:0] SEED = 16'h1C7F;
    localparam int unsigned SMAX = (1 << SW) - 1;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    minigame_round_if #(.SCORE_W(SW)) bus ();

    minigame_round_ctrl #(
        .TIMEOUT_CYCLES(T),
        .LIVES         (L),
        .SEED          (SEED),
        .SCORE_W       (SW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] mlfsr;
    logic [1:0]  exp_target;
    int          exp_score;
    int          exp_lives;
    int          exp_window;
    bit          over;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // One clock edge; the model LFSR follows the spec rule, then sample 1ns later
    task automatic tick();
        @(posedge clock);
        if (reset) mlfsr = SEED;
        else       mlfsr = lfsr_next(mlfsr);
        #1;
    endtask

    function automatic logic [31:0] pulses();
        return {29'd0, bus.correct_p, bus.wrong_p, bus.timeout_p};
    endfunction

    task automatic do_reset();
        reset = 1'b1; bus.start = 1'b0; bus.button = 4'd0;
        tick();
        reset = 1'b0;
        exp_score = 0; exp_lives = L; exp_window = T; over = 1'b0;
        chk("rst_target", 32'(bus.target), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_lives", 32'(bus.lives), L);
        chk("rst_time_left", bus.time_left, 0);
        chk("rst_round_active", 32'(bus.round_active), 0);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_pulses", pulses(), 0);
    endtask

    // Called during the NEW_ROUND cycle: target comes from the current LFSR value
    task automatic enter_round();
        exp_target = mlfsr[1:0];
        tick();
        chk("target", 32'(bus.target), 32'(exp_target));
        chk("ra_release", 32'(bus.round_active), 0);
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_score = 0; exp_lives = L; exp_window = T; over = 1'b0;
        chk("start_score", 32'(bus.score), 0);
        chk("start_lives", 32'(bus.lives), L);
        chk("start_game_over", 32'(bus.game_over), 0);
        enter_round();
    endtask

    // Play one round from WAIT_RELEASE with buttons released. idle >= window means timeout.
    task automatic play(input int idle, input logic [3:0] pat);
        int          w;
        int          nw;
        logic [31:0] exp_p;
        logic [3:0]  want;
        w = exp_window;
        tick();
        chk("ra_rise", 32'(bus.round_active), 1);
        chk("tl_load", bus.time_left, 32'(w));
        for (int i = 1; i < w && i <= idle; i++) begin
            tick();
            chk("tl_dec", bus.time_left, 32'(w - i));
        end
        want = 4'b0001 << exp_target;
        if (idle >= w) begin
            tick();
            exp_p = 32'd1;
            if (exp_lives > 0) exp_lives--;
        end else begin
            bus.button = pat;
            tick();
            bus.button = 4'd0;
            if (pat == want) begin
                exp_p = 32'd4;
                if (exp_score < SMAX) exp_score++;
`ifdef ROUND_SPEEDUP_EN
                nw = exp_window - exp_window / 8;
                exp_window = (nw < T / 4) ? T / 4 : nw;
`endif
            end else begin
                exp_p = 32'd2;
                if (exp_lives > 0) exp_lives--;
            end
        end
        chk("pulse", pulses(), exp_p);
        chk("score", 32'(bus.score), 32'(exp_score));
        chk("lives", 32'(bus.lives), 32'(exp_lives));
        chk("ra_fall", 32'(bus.round_active), 0);
        chk("tl_zero", bus.time_left, 0);
        tick();
        chk("pulse_once", pulses(), 0);
        if (exp_lives == 0) begin
            over = 1'b1;
            chk("game_over", 32'(bus.game_over), 1);
        end else begin
            chk("no_game_over", 32'(bus.game_over), 0);
            enter_round();
        end
    endtask

    function automatic logic [3:0] other_key(input logic [1:0] t);
        logic [1:0] o;
        o = t + 2'(1 + $urandom_range(0, 2));
        return 4'b0001 << o;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        int         sel;
        mlfsr = SEED;
        do_reset();

        // Correct press after 5 idle cycles
        start_game();
        play(5, 4'b0001 << exp_target);
        // Wrong single key, then all keys -> game over with score held
        play(2, other_key(exp_target));
        play(0, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("go_hold", 32'(bus.game_over), 1);
            chk("go_score", 32'(bus.score), 1);
            chk("go_lives", 32'(bus.lives), 0);
        end

        // Restart from GAME_OVER; timeout, then a press exactly on time_left==1
        start_game();
        play(T, 4'b0000);
        play(T - 1, 4'b0001 << exp_target);

        // Held key blocks the window; start is ignored mid-round
        bus.button = 4'b0001 << exp_target;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            chk("held_ra", 32'(bus.round_active), 0);
            chk("held_pulse", pulses(), 0);
            chk("held_score", 32'(bus.score), 32'(exp_score));
        end
        bus.button = 4'd0;
        play(3, 4'b0001 << exp_target);

        // Reset inside the press window
        tick();
        chk("pre_rst_ra", 32'(bus.round_active), 1);
        tick();
        do_reset();
        tick();
        chk("post_rst_ra", 32'(bus.round_active), 0);
        chk("post_rst_pulse", pulses(), 0);

        // Score saturation
        start_game();
        for (int i = 0; i < SMAX + 2; i++) play($urandom_range(0, 6), 4'b0001 << exp_target);
        chk("score_sat", 32'(bus.score), SMAX);

        // Randomized rounds
        for (int r = 0; r < 60; r++) begin
            if (over) start_game();
            sel = $urandom_range(0, 3);
            case (sel)
                0, 1:    p = 4'b0001 << exp_target;
                2:       p = other_key(exp_target);
                default: p = 4'($urandom_range(1, 15));
            endcase
            play($urandom_range(0, T + 1), p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
